// File: rtl/add_check_pkg.sv
// Shared types for the adder response checker: FSM states and the expected-value delay-line entry.
package add_check_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} chk_state_t;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] exp;
    } exp_ent_t;

endpackage

// File: rtl/add_exp_delay.sv
// Purpose: LATENCY-stage shift register of expected-value entries, with synchronous flush.
// Latency: LATENCY cycles from head to tail.
// Backpressure: none; shifts every cycle, flush clears every stage.
module add_exp_delay
    import add_check_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     flush,
    input  exp_ent_t head,
    output exp_ent_t tail
);

    exp_ent_t stage [LATENCY];

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= head;
            for (int i = 1; i < LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tail = stage[LATENCY-1];

endmodule

// File: rtl/add_resp_checker.sv
// Purpose: predicts the registered adder result from its stimulus and compares it with y; optional
// first-mismatch capture under ADD_RESP_CHECKER_FIRST_ERR_EN. Latency: compare LATENCY cycles after
// the en-qualified operands. Backpressure: none; stimulus outside RUN is ignored.
module add_resp_checker #(
    parameter int WIDTH      = 8,
    parameter int LATENCY    = 1,
    parameter int NUM_CHECKS = 10,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_act
);

    import add_check_pkg::*;

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("add_resp_checker: LATENCY must be >= 1");
        end
        if (WIDTH != add_check_pkg::WIDTH) begin : g_bad_width
            $error("add_resp_checker: WIDTH must match add_check_pkg::WIDTH");
        end
    endgenerate

    chk_state_t state, state_nxt;
    exp_ent_t   head, tail;
    logic       start_acc, cmp, mis, last;

    assign start_acc = start && (state != ST_RUN);
    assign head.vld  = en && (state == ST_RUN);
    assign head.exp  = a + b;

    // start in IDLE/DONE also flushes anything still in flight from the previous run
    add_exp_delay #(.LATENCY(LATENCY)) u_delay (
        .clock (clock),
        .reset (reset),
        .flush (start_acc),
        .head  (head),
        .tail  (tail)
    );

    assign cmp  = (state == ST_RUN) && tail.vld;
    assign mis  = cmp && (tail.exp != y);
    assign last = cmp && (check_cnt == CNT_W'(NUM_CHECKS - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last)  state_nxt = ST_DONE;
            ST_DONE: if (start) state_nxt = ST_RUN;
            default:            state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset || start_acc) begin
            check_cnt <= '0;
            err_cnt   <= '0;
        end else if (cmp) begin
            check_cnt <= check_cnt + 1'b1;
            if (mis && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

`ifdef ADD_RESP_CHECKER_FIRST_ERR_EN
    always_ff @(posedge clock) begin
        if (!reset || start_acc) begin
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_act <= '0;
        end else if (mis && (err_cnt == '0)) begin
            first_err_idx <= check_cnt;
            first_err_exp <= tail.exp;
            first_err_act <= y;
        end
    end
`else
    assign first_err_idx = '0;
    assign first_err_exp = '0;
    assign first_err_act = '0;
`endif

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_add_resp_checker.sv
// Directed bench: a registered-adder model drives y, with a one-cycle override to inject mismatches.
module tb_add_resp_checker;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  a, b, y;
    logic        en;
    logic        busy, done, pass;
    logic [15:0] check_cnt, err_cnt, first_err_idx;
    logic [7:0]  first_err_exp, first_err_act;

    logic [7:0]  y_reg;
    logic        ovr;
    logic [7:0]  ovr_val;

    int checks = 0;
    int errors = 0;

    add_resp_checker dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .a             (a),
        .b             (b),
        .en            (en),
        .y             (y),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .check_cnt     (check_cnt),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .first_err_exp (first_err_exp),
        .first_err_act (first_err_act)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial y_reg = 8'h00;
    always @(posedge clock) if (en) y_reg <= a + b;
    assign y = ovr ? ovr_val : y_reg;

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic wait_cnt(input logic [15:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (check_cnt === target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        checks++;
        if ({busy, done, pass} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {busy, done, pass});
        end
        checks++;
        if ({check_cnt, err_cnt, first_err_idx, first_err_exp, first_err_act} !== 64'd0) begin
            errors++; $display("FAIL reset_regs got cnt=%0d err=%0d idx=%0d exp=%h act=%h want all 0",
                              check_cnt, err_cnt, first_err_idx, first_err_exp, first_err_act);
        end
    endtask

    task automatic test_basic();
        int n;
        a = 8'hFD; b = 8'd18; en = 1'b1;
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
        wait_done(n);
        checks++;
        if (n != 11) begin errors++; $display("FAIL basic_latency got %0d want 11", n); end
        checks++;
        if ({done, pass, busy} !== 3'b110) begin
            errors++; $display("FAIL basic_flags got %b want 110", {done, pass, busy});
        end
        checks++;
        if (check_cnt !== 16'd10 || err_cnt !== 16'd0) begin
            errors++; $display("FAIL basic_counts got cnt=%0d err=%0d want 10/0", check_cnt, err_cnt);
        end
    endtask

    task automatic test_mismatch();
        int n;
        bit ok;
        a = 8'hFD; b = 8'd18; en = 1'b1;
        pulse_start();
        wait_cnt(16'd3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mis_reach3 got cnt=%0d want 3", check_cnt); end
        ovr = 1'b1; ovr_val = 8'd14;
        @(negedge clock);
        ovr = 1'b0;
        checks++;
        if (err_cnt !== 16'd1 || check_cnt !== 16'd4) begin
            errors++; $display("FAIL mis_count got cnt=%0d err=%0d want 4/1", check_cnt, err_cnt);
        end
        wait_done(n);
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || err_cnt !== 16'd1 || check_cnt !== 16'd10) begin
            errors++; $display("FAIL mis_end got done=%b pass=%b err=%0d cnt=%0d want 1/0/1/10",
                              done, pass, err_cnt, check_cnt);
        end
        checks++;
`ifdef ADD_RESP_CHECKER_FIRST_ERR_EN
        if (first_err_idx !== 16'd3 || first_err_exp !== 8'd15 || first_err_act !== 8'd14) begin
            errors++; $display("FAIL mis_first got idx=%0d exp=%0d act=%0d want 3/15/14",
                              first_err_idx, first_err_exp, first_err_act);
        end
`else
        if (first_err_idx !== 16'd0 || first_err_exp !== 8'd0 || first_err_act !== 8'd0) begin
            errors++; $display("FAIL mis_first got idx=%0d exp=%0d act=%0d want 0/0/0",
                              first_err_idx, first_err_exp, first_err_act);
        end
`endif
    endtask

    task automatic test_last_compare();
        bit ok;
        a = 8'd40; b = 8'd2; en = 1'b1;
        pulse_start();
        checks++;
        if (err_cnt !== 16'd0) begin errors++; $display("FAIL last_clear got err=%0d want 0", err_cnt); end
        wait_cnt(16'd9, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL last_reach9 got cnt=%0d want 9", check_cnt); end
        ovr = 1'b1; ovr_val = 8'd0;
        @(negedge clock);
        ovr = 1'b0;
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || err_cnt !== 16'd1 || check_cnt !== 16'd10) begin
            errors++; $display("FAIL last_end got done=%b pass=%b err=%0d cnt=%0d want 1/0/1/10",
                              done, pass, err_cnt, check_cnt);
        end
    endtask

    task automatic test_bubbles();
        int n;
        bit ok;
        a = 8'd5; b = 8'd9; en = 1'b1;
        pulse_start();
        wait_cnt(16'd4, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bub_reach4 got cnt=%0d want 4", check_cnt); end
        en = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (check_cnt !== 16'd5) begin errors++; $display("FAIL bub_hold got cnt=%0d want 5", check_cnt); end
        en = 1'b1;
        wait_done(n);
        checks++;
        if (n != 6) begin errors++; $display("FAIL bub_latency got %0d want 6", n); end
        checks++;
        if (pass !== 1'b1 || check_cnt !== 16'd10) begin
            errors++; $display("FAIL bub_end got pass=%b cnt=%0d want 1/10", pass, check_cnt);
        end
    endtask

    task automatic test_wrap();
        int n;
        bit ok;
        a = 8'd127; b = 8'd1; en = 1'b1;
        pulse_start();
        wait_done(n);
        checks++;
        if (pass !== 1'b1 || err_cnt !== 16'd0) begin
            errors++; $display("FAIL wrap_pass got pass=%b err=%0d want 1/0", pass, err_cnt);
        end
        // a saturating adder answer (+127) must be flagged
        pulse_start();
        wait_cnt(16'd2, ok);
        ovr = 1'b1; ovr_val = 8'h7F;
        @(negedge clock);
        ovr = 1'b0;
        wait_done(n);
        checks++;
        if (pass !== 1'b0 || err_cnt !== 16'd1) begin
            errors++; $display("FAIL wrap_sat got pass=%b err=%0d want 0/1", pass, err_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        int n;
        bit ok;
        a = 8'd1; b = 8'd2; en = 1'b1;
        pulse_start();
        wait_cnt(16'd5, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_reach5 got cnt=%0d want 5", check_cnt); end
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        checks++;
        if ({busy, done, pass} !== 3'b000 || check_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_mid got flags=%b cnt=%0d err=%0d want 000/0/0",
                              {busy, done, pass}, check_cnt, err_cnt);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || check_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_idle got busy=%b cnt=%0d want 0/0", busy, check_cnt);
        end
        pulse_start();
        @(negedge clock);
        checks++;
        if (check_cnt !== 16'd0) begin errors++; $display("FAIL rst_new0 got cnt=%0d want 0", check_cnt); end
        @(negedge clock);
        checks++;
        if (check_cnt !== 16'd1) begin errors++; $display("FAIL rst_new1 got cnt=%0d want 1", check_cnt); end
        wait_done(n);
        checks++;
        if (pass !== 1'b1 || check_cnt !== 16'd10) begin
            errors++; $display("FAIL rst_end got pass=%b cnt=%0d want 1/10", pass, check_cnt);
        end
    endtask

    task automatic test_restart();
        int n;
        bit ok;
        a = 8'hF0; b = 8'h20; en = 1'b1;
        pulse_start();
        wait_cnt(16'd4, ok);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || check_cnt !== 16'd5) begin
            errors++; $display("FAIL rs_ignore got busy=%b cnt=%0d want 1/5", busy, check_cnt);
        end
        wait_done(n);
        checks++;
        if (n != 5 || check_cnt !== 16'd10) begin
            errors++; $display("FAIL rs_end got n=%0d cnt=%0d want 5/10", n, check_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            en = i[0];
            @(negedge clock);
        end
        en = 1'b1;
        checks++;
        if (done !== 1'b1 || check_cnt !== 16'd10 || pass !== 1'b1) begin
            errors++; $display("FAIL rs_hold got done=%b cnt=%0d pass=%b want 1/10/1", done, check_cnt, pass);
        end
        pulse_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || check_cnt !== 16'd0) begin
            errors++; $display("FAIL rs_done_start got busy=%b done=%b cnt=%0d want 1/0/0",
                              busy, done, check_cnt);
        end
        wait_done(n);
        checks++;
        if (n != 11 || check_cnt !== 16'd10 || pass !== 1'b1) begin
            errors++; $display("FAIL rs_full got n=%0d cnt=%0d pass=%b want 11/10/1", n, check_cnt, pass);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; a = '0; b = '0; en = 1'b0;
        ovr = 1'b0; ovr_val = '0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_mismatch();
        test_last_compare();
        test_bubbles();
        test_wrap();
        test_reset_midrun();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
